// File: rtl/gpu_pixel_writer.sv
// -----------------------------------------------------------------------------
// gpu_pixel_writer
//
// Consumer end of the GPU pixel output stream. Accepts one pixel per
// valid/ready handshake, drops off-screen coordinates (counting them),
// converts (x, y) to a linear frame-buffer address, buffers address+data in a
// small FIFO and drains the FIFO through a single-outstanding write
// request/acknowledge interface toward the frame-buffer memory controller.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pix_valid_i     pixel present on x_i/y_i/r_i/g_i/b_i
//   pix_ready_o     block accepts a pixel this cycle (FIFO not full)
//   x_i, y_i        pixel column / row
//   r_i, g_i, b_i   colour channels
//   mem_wr_o        write request (held until mem_ack_i)
//   mem_addr_o      linear address y*SCREEN_WIDTH + x
//   mem_data_o      {r, g, b}, r in the MSBs
//   mem_ack_i       memory has taken the current write
//   idle_o          FIFO empty and no write outstanding
//   drop_count_o    saturating count of discarded off-screen pixels
//   dbg_state_o     current write FSM state (0 = IDLE, 1 = WRITE)
//
// Handshakes:
//   Input : a pixel transfers on a rising edge where pix_valid_i and
//           pix_ready_o are both high. pix_ready_o depends only on the
//           registered FIFO count, never on mem_ack_i. Off-screen pixels
//           still transfer (and are then discarded).
//   Output: mem_wr_o high means mem_addr_o/mem_data_o carry a write that
//           stays stable until a rising edge with mem_ack_i high completes
//           it. mem_ack_i is ignored while mem_wr_o is low.
// -----------------------------------------------------------------------------
module gpu_pixel_writer #(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 9,
  parameter int CHANNEL_BITS  = 8,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ADDR_BITS     = 19,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid_i,
  output logic                      pix_ready_o,
  input  logic [WIDTH_BITS-1:0]     x_i,
  input  logic [HEIGHT_BITS-1:0]    y_i,
  input  logic [CHANNEL_BITS-1:0]   r_i,
  input  logic [CHANNEL_BITS-1:0]   g_i,
  input  logic [CHANNEL_BITS-1:0]   b_i,
  output logic                      mem_wr_o,
  output logic [ADDR_BITS-1:0]      mem_addr_o,
  output logic [3*CHANNEL_BITS-1:0] mem_data_o,
  input  logic                      mem_ack_i,
  output logic                      idle_o,
  output logic [7:0]                drop_count_o,
  output logic                      dbg_state_o
);

  localparam int DATA_BITS = 3 * CHANNEL_BITS;
  localparam int PTR_BITS  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_BITS-1:0] PTR_ONE = PTR_BITS'(1);
  localparam logic [PTR_BITS:0]   CNT_ONE = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS:0]   CNT_MAX = (PTR_BITS + 1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_mem_wr;
  logic [ADDR_BITS-1:0]  r_mem_addr;
  logic [DATA_BITS-1:0]  r_mem_data;
  logic [7:0]            r_drop_count;

  logic [ADDR_BITS-1:0]  r_fifo_addr [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   r_wptr;
  logic [PTR_BITS-1:0]   r_rptr;
  logic [PTR_BITS:0]     r_count;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_onscreen;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_BITS-1:0]  w_addr;
  logic [DATA_BITS-1:0]  w_data;

  assign w_full   = (r_count == CNT_MAX);
  assign w_empty  = (r_count == '0);
  assign w_accept = pix_valid_i && !w_full;

  assign w_onscreen = (32'(x_i) < 32'(SCREEN_WIDTH)) &&
                      (32'(y_i) < 32'(SCREEN_HEIGHT));

  assign w_push = w_accept && w_onscreen;

  // Pop whenever the output register is free: either idle, or the current
  // write is being acknowledged this edge (back-to-back, no bubble). Uses the
  // registered count only, so a pixel pushed this edge is never popped with it.
  assign w_pop = !w_empty && ((r_state == S_IDLE) || mem_ack_i);

  // Arithmetic in ADDR_BITS context gives the required truncation directly.
  assign w_addr = ADDR_BITS'(y_i) * ADDR_BITS'(SCREEN_WIDTH) + ADDR_BITS'(x_i);
  assign w_data = {r_i, g_i, b_i};

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset needed: contents are qualified by r_count)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= w_addr;
      r_fifo_data[r_wptr] <= w_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Off-screen drop counter (saturating)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= 8'd0;
    end else if (w_accept && !w_onscreen && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM with registered memory-side outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_mem_addr <= r_fifo_addr[r_rptr];
            r_mem_data <= r_fifo_data[r_rptr];
            r_mem_wr   <= 1'b1;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ack_i) begin
            if (!w_empty) begin
              r_mem_addr <= r_fifo_addr[r_rptr];
              r_mem_data <= r_fifo_data[r_rptr];
              r_mem_wr   <= 1'b1;
            end else begin
              r_mem_wr <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        default: begin
          r_mem_wr <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pix_ready_o  = !w_full;
  assign idle_o       = (r_state == S_IDLE) && w_empty;
  assign mem_wr_o     = r_mem_wr;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign drop_count_o = r_drop_count;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_gpu_pixel_writer
//
// Directed bench for gpu_pixel_writer. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point (away from the edge).
// Completed memory writes ({addr, data}) are collected into got_q and compared
// against hand-computed entries in exp_q.
// -----------------------------------------------------------------------------
module tb_gpu_pixel_writer;

  localparam int W = 19 + 24;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [9:0]  x_i;
  logic [8:0]  y_i;
  logic [7:0]  r_i;
  logic [7:0]  g_i;
  logic [7:0]  b_i;
  logic        mem_wr_o;
  logic [18:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic        mem_ack_i;
  logic        idle_o;
  logic [7:0]  drop_count_o;
  logic        dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  gpu_pixel_writer dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .x_i          (x_i),
    .y_i          (y_i),
    .r_i          (r_i),
    .g_i          (g_i),
    .b_i          (b_i),
    .mem_wr_o     (mem_wr_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .idle_o       (idle_o),
    .drop_count_o (drop_count_o),
    .dbg_state_o  (dbg_state_o)
  );

  // Collect every completed write (request high and acknowledged at an edge).
  always @(posedge clk) begin
    if (!rst && mem_wr_o && mem_ack_i) begin
      got_q.push_back({mem_addr_o, mem_data_o});
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left 1 unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive_pixel(input logic [9:0] x, input logic [8:0] y,
                             input logic [23:0] rgb);
    pix_valid_i = 1'b1;
    x_i = x;
    y_i = y;
    {r_i, g_i, b_i} = rgb;
    @(posedge clk);
    #1;
    pix_valid_i = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    n_checks++;
    if (pix_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", pix_ready_o);
    end
    n_checks++;
    if (mem_wr_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr: got %b want 0", mem_wr_o);
    end
    n_checks++;
    if (mem_addr_o !== 19'd0) begin
      n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_addr_o);
    end
    n_checks++;
    if (mem_data_o !== 24'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 000000", mem_data_o);
    end
    n_checks++;
    if (idle_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: got %b want 1", idle_o);
    end
    n_checks++;
    if (drop_count_o !== 8'd0) begin
      n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count_o);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single_pixel;
    mem_ack_i = 1'b1;
    got_q.delete();
    drive_pixel(10'd5, 9'd2, 24'hAABBCC);   // accepted at edge N
    n_checks++;
    if (mem_wr_o !== 1'b0 || idle_o !== 1'b0) begin
      n_fail++; $display("FAIL single_after_accept: wr=%b idle=%b want wr=0 idle=0",
                         mem_wr_o, idle_o);
    end
    tick(1);                                 // edge N+1
    n_checks++;
    if (mem_wr_o !== 1'b1) begin
      n_fail++; $display("FAIL single_wr: got %b want 1", mem_wr_o);
    end
    n_checks++;
    if (mem_addr_o !== 19'd1285) begin
      n_fail++; $display("FAIL single_addr: got %0d want 1285", mem_addr_o);
    end
    n_checks++;
    if (mem_data_o !== 24'hAABBCC) begin
      n_fail++; $display("FAIL single_data: got %h want aabbcc", mem_data_o);
    end
    tick(1);                                 // edge N+2: ack taken
    n_checks++;
    if (mem_wr_o !== 1'b0 || idle_o !== 1'b1) begin
      n_fail++; $display("FAIL single_done: wr=%b idle=%b want wr=0 idle=1",
                         mem_wr_o, idle_o);
    end
    n_checks++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d writes want 1", got_q.size());
    end
  endtask

  task automatic test_back_pressure;
    logic [9:0]  xs [5];
    logic [8:0]  ys [5];
    logic [18:0] as [5];
    int n;
    xs = '{10'd10, 10'd11, 10'd12, 10'd13, 10'd14};
    ys = '{9'd0,   9'd0,   9'd1,   9'd1,   9'd2};
    as = '{19'd10, 19'd11, 19'd652, 19'd653, 19'd1294};
    mem_ack_i = 1'b0;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({as[i], 24'(i + 1)});
      drive_pixel(xs[i], ys[i], 24'(i + 1));
    end
    n_checks++;
    if (pix_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_low: got %b want 0", pix_ready_o);
    end
    n_checks++;
    if (mem_wr_o !== 1'b1 || mem_addr_o !== 19'd10 || mem_data_o !== 24'd1) begin
      n_fail++; $display("FAIL bp_head: wr=%b addr=%0d data=%h want 1/10/000001",
                         mem_wr_o, mem_addr_o, mem_data_o);
    end
    tick(3);
    n_checks++;
    if (mem_addr_o !== 19'd10 || mem_data_o !== 24'd1 || pix_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_stable: addr=%0d data=%h ready=%b want 10/000001/0",
                         mem_addr_o, mem_data_o, pix_ready_o);
    end
    mem_ack_i = 1'b1;
    n = 0;
    while (!idle_o && n < 50) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (idle_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain_timeout: idle=%b want 1", idle_o);
    end
    n_checks++;
    if (pix_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_back: got %b want 1", pix_ready_o);
    end
    n_checks++;
    if (got_q.size() != 5) begin
      n_fail++; $display("FAIL bp_count: got %0d writes want 5", got_q.size());
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_corners;
    int n;
    mem_ack_i = 1'b1;
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({19'd307199, 24'h123456});
    exp_q.push_back({19'd0,      24'h654321});
    drive_pixel(10'd639, 9'd479, 24'h123456);
    drive_pixel(10'd0,   9'd0,   24'h654321);
    n = 0;
    while (!idle_o && n < 20) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL corner_count: got %0d writes want 2", got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL corner[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_offscreen;
    logic ready_dropped;
    mem_ack_i = 1'b1;
    got_q.delete();
    drive_pixel(10'd640, 9'd0,   24'h111111);
    drive_pixel(10'd0,   9'd480, 24'h222222);
    drive_pixel(10'd700, 9'd500, 24'h333333);
    tick(4);
    n_checks++;
    if (drop_count_o !== 8'd3) begin
      n_fail++; $display("FAIL drop_three: got %0d want 3", drop_count_o);
    end
    n_checks++;
    if (got_q.size() != 0 || idle_o !== 1'b1) begin
      n_fail++; $display("FAIL drop_no_write: writes=%0d idle=%b want 0/1",
                         got_q.size(), idle_o);
    end
    ready_dropped = 1'b0;
    pix_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x_i = 10'(640 + (i % 300));
      y_i = 9'(i % 480);
      @(posedge clk);
      #1;
      if (pix_ready_o !== 1'b1) ready_dropped = 1'b1;
    end
    pix_valid_i = 1'b0;
    tick(2);
    n_checks++;
    if (drop_count_o !== 8'd255) begin
      n_fail++; $display("FAIL drop_saturate: got %0d want 255", drop_count_o);
    end
    n_checks++;
    if (ready_dropped !== 1'b0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL drop_stream: ready_low_seen=%b writes=%0d want 0/0",
                         ready_dropped, got_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] wr_seen;
    logic [17:0] wr_exp;
    mem_ack_i = 1'b1;
    got_q.delete();
    exp_q.delete();
    wr_seen = '0;
    wr_exp  = '0;
    for (int k = 1; k <= 18; k++) begin
      wr_exp[k-1] = (k >= 2) && (k <= 17);
    end
    pix_valid_i = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k <= 16) begin
        x_i = 10'(k - 1);
        y_i = 9'd3;
        {r_i, g_i, b_i} = 24'((k - 1) * 24'h010101);
        exp_q.push_back({19'(3 * 640 + (k - 1)), 24'((k - 1) * 24'h010101)});
      end else begin
        pix_valid_i = 1'b0;
      end
      @(posedge clk);
      #1;
      wr_seen[k-1] = mem_wr_o;
    end
    pix_valid_i = 1'b0;
    n_checks++;
    if (wr_seen !== wr_exp) begin
      n_fail++; $display("FAIL stream_wr_pattern: got %b want %b", wr_seen, wr_exp);
    end
    n_checks++;
    if (got_q.size() != 16) begin
      n_fail++; $display("FAIL stream_count: got %0d writes want 16", got_q.size());
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stream[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    logic wr_after;
    mem_ack_i = 1'b0;
    got_q.delete();
    drive_pixel(10'd20, 9'd0, 24'hA00001);
    drive_pixel(10'd21, 9'd0, 24'hA00002);
    drive_pixel(10'd22, 9'd0, 24'hA00003);
    drive_pixel(10'd23, 9'd0, 24'hA00004);
    n_checks++;
    if (mem_wr_o !== 1'b1 || mem_addr_o !== 19'd20) begin
      n_fail++; $display("FAIL rstmid_pre: wr=%b addr=%0d want 1/20", mem_wr_o, mem_addr_o);
    end
    #3;
    rst = 1'b1;   // mid-cycle: reset must act without a clock edge
    #1;
    n_checks++;
    if (mem_wr_o !== 1'b0 || mem_addr_o !== 19'd0 || mem_data_o !== 24'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: wr=%b addr=%0d data=%h want 0/0/000000",
                         mem_wr_o, mem_addr_o, mem_data_o);
    end
    n_checks++;
    if (pix_ready_o !== 1'b1 || idle_o !== 1'b1 || drop_count_o !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_status: ready=%b idle=%b drop=%0d want 1/1/0",
                         pix_ready_o, idle_o, drop_count_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ack_i = 1'b1;
    wr_after = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (mem_wr_o !== 1'b0) wr_after = 1'b1;
    end
    n_checks++;
    if (wr_after !== 1'b0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_no_write: wr_seen=%b writes=%0d want 0/0",
                         wr_after, got_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst         = 1'b1;
    pix_valid_i = 1'b0;
    mem_ack_i   = 1'b0;
    x_i = '0;
    y_i = '0;
    r_i = '0;
    g_i = '0;
    b_i = '0;
    tick(2);

    test_reset;
    test_single_pixel;
    test_back_pressure;
    test_corners;
    test_offscreen;
    test_back_to_back;
    test_reset_mid_write;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
